// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle logic/add/sub/shift ops plus an
// iterative shift-add multiplier behind a valid/ready handshake.
module alu_exec_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [WIDTH-1:0] acc_step_s;
  logic [WIDTH-1:0] mcand_step_s;
  logic [WIDTH-1:0] mplier_step_s;
  logic [WIDTH-1:0] mul_final_s;

  assign ready_o  = (state_q == S_IDLE);
  assign accept_s = valid_i & ready_o & ~rst_i;
  assign shamt_s  = data2_i[SHW-1:0];

  // Single-cycle result; codes 0 and 6 produce zero here.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    case (ALUCtrl_i)
      3'd1:    alu_res_s = data1_i & data2_i;
      3'd2:    alu_res_s = data1_i ^ data2_i;
      3'd3:    alu_res_s = data1_i << shamt_s;
      3'd4:    alu_res_s = data1_i + data2_i;
      3'd5:    alu_res_s = data1_i - data2_i;
      3'd7:    alu_res_s = $unsigned($signed(data1_i) >>> shamt_s);
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step, plus a lookahead of the following step so the
  // product reaches data_o one cycle before the final iteration retires.
  always_comb begin
    mcand_step_s  = mcand_q << 1;
    mplier_step_s = mplier_q >> 1;
    if (mplier_q[0]) begin
      acc_step_s = acc_q + mcand_q;
    end else begin
      acc_step_s = acc_q;
    end
    if (mplier_step_s[0]) begin
      mul_final_s = acc_step_s + mcand_step_s;
    end else begin
      mul_final_s = acc_step_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (ALUCtrl_i == 3'd6)) begin
          mcand_d  = data1_i;
          mplier_d = data2_i;
          acc_d    = {WIDTH{1'b0}};
          cnt_d    = {SHW{1'b0}};
          state_d  = S_MUL;
        end else if (accept_s) begin
          data_d  = alu_res_s;
          zero_d  = (alu_res_s == {WIDTH{1'b0}});
          valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_step_s;
        mcand_d  = mcand_step_s;
        mplier_d = mplier_step_s;
        cnt_d    = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == SHW'(WIDTH - 2)) begin
          data_d  = mul_final_s;
          zero_d  = (mul_final_s == {WIDTH{1'b0}});
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MUL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      data_q   <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected results with
// their expected arrival cycle, a negedge monitor pops and compares.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [2:0]       ALUCtrl_i = 3'd0;
  logic [WIDTH-1:0] data1_i = '0;
  logic [WIDTH-1:0] data2_i = '0;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .valid_o(valid_o), .data_o(data_o), .zero_o(zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid_o pulse must match the oldest expected result.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=%h expected=none (cycle %0d)", data_o, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result_data", data_o, e.data);
        chk("result_zero", 32'(zero_o), 32'(e.zero));
        chk("result_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge with ready_o expected high; returns one negedge later.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    exp_t e;
    chk("ready_at_issue", 32'(ready_o), 32'd1);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    if (push) begin
      e.data = exp;
      e.zero = (exp == 32'd0);
      e.cyc  = cyc + lat;
      sb_q.push_back(e);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_data", data_o, 32'd0);
    chk("reset_zero", 32'(zero_o), 32'd1);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ready", 32'(ready_o), 32'd1);
    chk("idle_valid", 32'(valid_o), 32'd0);
    chk("idle_data", data_o, 32'd0);

    // Back-to-back single-cycle ops, one per cycle.
    issue(3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 1'b1);
    issue(3'd2, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1, 1'b1);
    issue(3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1'b1);
    issue(3'd5, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1, 1'b1);
    issue(3'd3, 32'h00000001, 32'h00000024, 32'h00000010, 1, 1'b1);
    issue(3'd7, 32'h80000000, 32'h00000004, 32'hF8000000, 1, 1'b1);
    issue(3'd7, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1, 1'b1);
    issue(3'd0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 1'b1);
    repeat (2) @(negedge clk_i);

    // mul 7 x -3 with ignored add requests during the busy window.
    issue(3'd6, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, WIDTH, 1'b1);
    for (int i = 1; i <= WIDTH; i++) begin
      chk("mul_busy_ready", 32'(ready_o), 32'd0);
      if (i <= 5) begin
        valid_i   = 1'b1;
        ALUCtrl_i = 3'd4;
        data1_i   = 32'd1;
        data2_i   = 32'd1;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk_i);
    end
    issue(3'd4, 32'd5, 32'd6, 32'd11, 1, 1'b1);
    @(negedge clk_i);

    // mul whose multiplier MSB matters.
    issue(3'd6, 32'h00000003, 32'h80000001, 32'h80000003, WIDTH, 1'b1);
    repeat (WIDTH) @(negedge clk_i);
    chk("mul2_ready_after", 32'(ready_o), 32'd1);

    // Reset mid-mul: aborted product never appears.
    issue(3'd6, 32'h00001234, 32'h00000010, 32'h00012340, WIDTH, 1'b0);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_data", data_o, 32'd0);
    chk("abort_zero", 32'(zero_o), 32'd1);
    repeat (WIDTH + 4) @(negedge clk_i);
    issue(3'd4, 32'd2, 32'd2, 32'd4, 1, 1'b1);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
